// File: rtl/vdic_dut_2022_pkg.sv
// Shared types and constants for the serial command-link receiver.
package vdic_dut_2022_pkg;

  // Serial word geometry: w[9] type, w[8:1] byte (MSB first), w[0] parity.
  localparam int   RX_WORD_W    = 10;
  localparam logic RX_TYPE_DATA = 1'b0;
  localparam logic RX_TYPE_CMD  = 1'b1;

  // Frame status, lowest encoding is the healthy case.
  typedef enum logic [1:0] {
    RX_OK         = 2'd0,
    RX_ERR_PARITY = 2'd1,
    RX_ERR_NARGS  = 2'd2,
    RX_ERR_FRAME  = 2'd3
  } rx_stat_t;

  // Receiver sequencing states.
  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_IDLE = 3'd1,
    ST_RX   = 3'd2,
    ST_DONE = 3'd3,
    ST_TAIL = 3'd4
  } rx_state_t;

  // Parity bit that makes a word valid: w[0] must equal the XOR of w[9:1].
  function automatic logic rx_parity(input logic word_type, input logic [7:0] word_byte);
    return ^{word_type, word_byte};
  endfunction

endpackage

// File: rtl/vdic_serial_word_shift.sv
// Serial-to-parallel word shifter. Collects RX_WORD_W bits MSB first and
// presents the finished word for one cycle through a registered strobe,
// together with its parity verdict.
module vdic_serial_word_shift
  import vdic_dut_2022_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       din,
  output logic       word_type,
  output logic [7:0] word_byte,
  output logic       word_done,
  output logic       par_ok
);

  localparam logic [3:0] LAST_BIT = 4'(RX_WORD_W - 1);

  logic [RX_WORD_W-2:0] shreg;
  logic [3:0]           bit_cnt;

  // Shift one bit per enabled cycle; on the last bit capture the whole word
  // and its parity check, and pulse word_done for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_type <= 1'b0;
      word_byte <= '0;
      word_done <= 1'b0;
      par_ok    <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (shift_en) begin
        if (bit_cnt == LAST_BIT) begin
          word_type <= shreg[8];
          word_byte <= shreg[7:0];
          par_ok    <= (din == ^shreg);
          word_done <= 1'b1;
          bit_cnt   <= '0;
          shreg     <= '0;
        end else begin
          shreg   <= {shreg[RX_WORD_W-3:0], din};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vdic_serial_frame_rx.sv
// Receiver for the serial command link. Deserialises words while enable_n is
// low, collects data bytes until the command word, and offers one parallel
// frame to the core.
//
// Handshake: frame_valid/frame_* are held stable while frame_valid is high and
// frame_ready is low; a transfer happens on a rising edge where both are high,
// after which frame_valid drops unless a new frame loads in that same cycle.
// A frame that completes while the previous one is still unaccepted is
// dropped and rx_overrun pulses for one cycle.
module vdic_serial_frame_rx
  import vdic_dut_2022_pkg::*;
#(
  parameter int MAX_ARGS = 9,
  parameter int MIN_ARGS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_n,
  input  logic                  din,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [7:0]            frame_cmd,
  output logic [8*MAX_ARGS-1:0] frame_args,
  output logic [3:0]            frame_nargs,
  output rx_stat_t              frame_status,
  output logic                  rx_busy,
  output logic                  rx_overrun
);

  localparam logic [3:0] MAX_N = 4'(MAX_ARGS);
  localparam logic [3:0] MIN_N = 4'(MIN_ARGS);
  localparam logic [3:0] SAT_N = 4'(MAX_ARGS + 1);

  rx_state_t             state;
  logic [3:0]            nargs_q;
  logic [8*MAX_ARGS-1:0] args_q;
  logic [7:0]            cmd_q;
  logic                  par_err_q;
  logic                  frm_err_q;
  rx_stat_t              stat_d;

  logic                  shift_en;
  logic                  shift_clr;
  logic                  word_type;
  logic [7:0]            word_byte;
  logic                  word_done;
  logic                  par_ok;

  // The shifter only listens while waiting for or inside a frame; elsewhere it
  // is held cleared so every frame starts at bit 0 and trailing words are ignored.
  assign shift_en  = !enable_n && (state == ST_IDLE || state == ST_RX);
  assign shift_clr = !(state == ST_IDLE || state == ST_RX);
  assign rx_busy   = (state == ST_RX) || (state == ST_DONE) || (state == ST_TAIL);

  vdic_serial_word_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (shift_clr),
    .shift_en  (shift_en),
    .din       (din),
    .word_type (word_type),
    .word_byte (word_byte),
    .word_done (word_done),
    .par_ok    (par_ok)
  );

  // Frame status by priority: framing, then parity, then argument count.
  always_comb begin
    stat_d = RX_OK;
    if (frm_err_q)                             stat_d = RX_ERR_FRAME;
    else if (par_err_q)                        stat_d = RX_ERR_PARITY;
    else if (nargs_q < MIN_N || nargs_q > MAX_N) stat_d = RX_ERR_NARGS;
  end

  // Receiver FSM, argument buffer and output register with handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SYNC;
      nargs_q      <= '0;
      args_q       <= '0;
      cmd_q        <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      frame_valid  <= 1'b0;
      frame_cmd    <= '0;
      frame_args   <= '0;
      frame_nargs  <= '0;
      frame_status <= RX_OK;
      rx_overrun   <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frame_valid && frame_ready) frame_valid <= 1'b0;

      case (state)
        ST_SYNC: begin
          // Wait for the link to go quiet so we never join a frame mid-way.
          if (enable_n) state <= ST_IDLE;
        end

        ST_IDLE: begin
          nargs_q   <= '0;
          args_q    <= '0;
          cmd_q     <= '0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
          if (!enable_n) state <= ST_RX;
        end

        ST_RX: begin
          if (word_done) begin
            if (word_type == RX_TYPE_CMD) begin
              cmd_q <= word_byte;
              if (!par_ok) par_err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              for (int k = 0; k < MAX_ARGS; k++) begin
                if (nargs_q == 4'(k)) args_q[8*k +: 8] <= word_byte;
              end
              if (nargs_q != SAT_N) nargs_q <= nargs_q + 4'd1;
              if (!par_ok) par_err_q <= 1'b1;
              // Gate closing right after a data word still means no command arrived.
              if (enable_n) begin
                frm_err_q <= 1'b1;
                state     <= ST_DONE;
              end
            end
          end else if (enable_n) begin
            frm_err_q <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (frame_valid && !frame_ready) begin
            rx_overrun <= 1'b1;
          end else begin
            frame_valid  <= 1'b1;
            frame_cmd    <= frm_err_q ? 8'h00 : cmd_q;
            frame_args   <= args_q;
            frame_nargs  <= nargs_q;
            frame_status <= stat_d;
          end
          state <= ST_TAIL;
        end

        ST_TAIL: begin
          if (enable_n) state <= ST_IDLE;
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_vdic_serial_frame_rx.sv
// Directed bench for vdic_serial_frame_rx with an expected-frame queue.
module tb_vdic_serial_frame_rx;
  import vdic_dut_2022_pkg::*;

  localparam int MAX_ARGS = 9;
  localparam int FW       = 8 + 8*MAX_ARGS + 4 + 2;

  logic                  clk;
  logic                  rst;
  logic                  enable_n;
  logic                  din;
  logic                  frame_ready;
  logic                  frame_valid;
  logic [7:0]            frame_cmd;
  logic [8*MAX_ARGS-1:0] frame_args;
  logic [3:0]            frame_nargs;
  rx_stat_t              frame_status;
  logic                  rx_busy;
  logic                  rx_overrun;

  logic [FW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;

  vdic_serial_frame_rx #(.MAX_ARGS(MAX_ARGS), .MIN_ARGS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_n     (enable_n),
    .din          (din),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_cmd    (frame_cmd),
    .frame_args   (frame_args),
    .frame_nargs  (frame_nargs),
    .frame_status (frame_status),
    .rx_busy      (rx_busy),
    .rx_overrun   (rx_overrun)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic t, input logic [7:0] b);
    return {t, b, ^{t, b}};
  endfunction

  function automatic logic [FW-1:0] pk(input logic [7:0] c, input logic [8*MAX_ARGS-1:0] a,
                                       input logic [3:0] n, input logic [1:0] s);
    return {c, a, n, s};
  endfunction

  function automatic logic [FW-1:0] dut_frame();
    return {frame_cmd, frame_args, frame_nargs, frame_status};
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic send_bits(input logic [9:0] w, input int nbits);
    for (int i = 9; i > 9 - nbits; i--) begin
      enable_n = 1'b0;
      din      = w[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    send_bits(w, 10);
  endtask

  task automatic idle(input int n);
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted frame is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rx_overrun) ovr_cnt++;
    if (!rst && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_frame observed=%h expected=none", dut_frame());
      end else begin
        chk("frame", dut_frame(), exp_q.pop_front());
      end
    end
  end

  logic [8*MAX_ARGS-1:0] args10;

  initial begin
    rst = 1'b1; enable_n = 1'b1; din = 1'b0; frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_frame", dut_frame(), '0);
    chk("reset_valid", FW'(frame_valid), '0);
    chk("reset_busy", FW'(rx_busy), '0);
    chk("reset_overrun", FW'(rx_overrun), '0);
    idle(3);

    // 1: two args, command, exact latency and single-cycle valid
    exp_q.push_back(pk(8'h01, 72'h3412, 4'd2, RX_OK));
    send_word(mk(1'b0, 8'h12));
    send_word(mk(1'b0, 8'h34));
    send_word(mk(1'b1, 8'h01));
    enable_n = 1'b1;
    chk("lat_edge0", FW'(frame_valid), '0);
    @(posedge clk); #1;
    chk("lat_edge1", FW'(frame_valid), '0);
    chk("busy_in_frame", FW'(rx_busy), FW'(1));
    @(posedge clk); #1;
    chk("lat_edge2", FW'(frame_valid), FW'(1));
    @(posedge clk); #1;
    chk("valid_one_cycle", FW'(frame_valid), '0);
    idle(3);
    chk("busy_idle", FW'(rx_busy), '0);

    // 2: parity flipped on first arg
    exp_q.push_back(pk(8'h01, 72'h3412, 4'd2, RX_ERR_PARITY));
    send_word(mk(1'b0, 8'h12) ^ 10'h001);
    send_word(mk(1'b0, 8'h34));
    send_word(mk(1'b1, 8'h01));
    idle(5);

    // 3a: too few args
    exp_q.push_back(pk(8'h01, 72'hFF, 4'd1, RX_ERR_NARGS));
    send_word(mk(1'b0, 8'hFF));
    send_word(mk(1'b1, 8'h01));
    idle(5);

    // 3b: ten args, only the first nine stored, count saturates at ten
    args10 = '0;
    for (int k = 0; k < MAX_ARGS; k++) args10[8*k +: 8] = 8'(k);
    exp_q.push_back(pk(8'h01, args10, 4'd10, RX_ERR_NARGS));
    for (int k = 0; k < 10; k++) send_word(mk(1'b0, 8'(k)));
    send_word(mk(1'b1, 8'h01));
    idle(5);

    // 4: gate released mid-word, then a clean frame
    exp_q.push_back(pk(8'h00, 72'h12, 4'd1, RX_ERR_FRAME));
    send_word(mk(1'b0, 8'h12));
    send_bits(mk(1'b0, 8'h34), 5);
    idle(6);
    exp_q.push_back(pk(8'h7E, 72'h5AA5, 4'd2, RX_OK));
    send_word(mk(1'b0, 8'hA5));
    send_word(mk(1'b0, 8'h5A));
    send_word(mk(1'b1, 8'h7E));
    idle(5);
    chk("no_overrun_yet", FW'(ovr_cnt), '0);

    // 5: core stalls, second frame overruns and is dropped
    frame_ready = 1'b0;
    exp_q.push_back(pk(8'h05, 72'h2211, 4'd2, RX_OK));
    send_word(mk(1'b0, 8'h11));
    send_word(mk(1'b0, 8'h22));
    send_word(mk(1'b1, 8'h05));
    idle(4);
    chk("stall_valid", FW'(frame_valid), FW'(1));
    send_word(mk(1'b0, 8'h33));
    send_word(mk(1'b0, 8'h44));
    send_word(mk(1'b1, 8'h06));
    idle(5);
    chk("overrun_pulses", FW'(ovr_cnt), FW'(1));
    chk("held_frame", dut_frame(), pk(8'h05, 72'h2211, 4'd2, RX_OK));
    chk("held_valid", FW'(frame_valid), FW'(1));
    frame_ready = 1'b1;
    idle(4);
    chk("after_accept_valid", FW'(frame_valid), '0);
    chk("after_accept_overrun", FW'(ovr_cnt), FW'(1));

    // 6: reset mid word 2 with the gate still low
    send_word(mk(1'b0, 8'h12));
    send_word(mk(1'b0, 8'h34));
    send_bits(mk(1'b0, 8'h56), 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", FW'(frame_valid), '0);
    for (int i = 0; i < 8; i++) begin
      enable_n = 1'b0;
      din      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("rst_mid_busy", FW'(rx_busy), '0);
    end
    idle(3);
    exp_q.push_back(pk(8'hC3, 72'h9988, 4'd2, RX_OK));
    send_word(mk(1'b0, 8'h88));
    send_word(mk(1'b0, 8'h99));
    send_word(mk(1'b1, 8'hC3));
    idle(2);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", FW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
